// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] IFETCH_NOP = 32'h0000_0000;
  localparam int          BEATS      = 4;

endpackage

// File: rtl/ifetch_wordbuf.sv
// One-entry word buffer: tag/data/valid with lookup, fill and flush.
// A fill and a flush in the same cycle leave the entry valid, so a fetch in flight completes its fill.
module ifetch_wordbuf #(
  parameter int TW = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [TW-1:0] i_lookup_tag,
  input  logic          i_flush,
  input  logic          i_fill_en,
  input  logic [TW-1:0] i_fill_tag,
  input  logic [31:0]   i_fill_data,
  output logic          o_hit,
  output logic [31:0]   o_data
);

  logic          r_valid;
  logic [TW-1:0] r_tag;
  logic [31:0]   r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill_en) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end
  end

  // A flush arriving with the lookup forces a miss.
  assign o_hit  = r_valid && (r_tag == i_lookup_tag) && !i_flush;
  assign o_data = r_data;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: assembles a 32-bit word from four big-endian byte beats,
// with a one-entry word buffer for repeat fetches and a per-beat ack timeout.
module instr_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          AW      = 16,
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] NOP     = IFETCH_NOP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instrreq,
  input  logic [31:0]   instradr,
  output logic [31:0]   instrF,
  output logic          instrabort,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  input  logic          flush,
  output logic          fetch_err
);

  localparam int TW = AW - 2;
  localparam int CW = $clog2(TIMEOUT + 1);

  fetch_state_t  r_state;
  logic [31:0]   r_instr;
  logic          r_abort;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [1:0]    r_beat;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_adr;
  logic          r_err;

  logic          w_hit;
  logic [31:0]   w_buf_data;
  logic [31:0]   w_word;
  logic          w_last;
  logic          w_fill;
  logic [1:0]    w_beat_nxt;
  logic [TW-1:0] w_req_tag;
  logic          w_unused;

  assign w_req_tag  = instradr[AW-1:2];
  assign w_unused   = ^{instradr[31:AW], instradr[1:0]};
  assign w_last     = (r_beat == 2'(BEATS - 1));
  assign w_beat_nxt = r_beat + 2'd1;
  assign w_fill     = (r_state == FETCH) && instrreq && mem_ack && w_last;

  // Current word with the arriving byte dropped into its lane; beat 0 is the MSB.
  always_comb begin
    w_word = r_instr;
    w_word[31 - 8*int'(r_beat) -: 8] = mem_rdata;
  end

  ifetch_wordbuf #(
    .TW(TW)
  ) u_wordbuf (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_lookup_tag(w_req_tag),
    .i_flush     (flush),
    .i_fill_en   (w_fill),
    .i_fill_tag  (r_adr),
    .i_fill_data (w_word),
    .o_hit       (w_hit),
    .o_data      (w_buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_abort    <= 1'b1;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_beat     <= '0;
      r_cnt      <= '0;
      r_adr      <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (instrreq) begin
            r_adr <= w_req_tag;
            if (w_hit) begin
              r_instr <= w_buf_data;
              r_abort <= 1'b0;
              r_state <= DONE;
            end else begin
              r_beat     <= '0;
              r_cnt      <= '0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {w_req_tag, 2'b00};
              r_state    <= FETCH;
            end
          end
        end
        FETCH: begin
          // Dropping the request abandons the fetch even if an ack is pending.
          if (!instrreq) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end else if (mem_ack) begin
            r_instr <= w_word;
            r_cnt   <= '0;
            r_beat  <= w_beat_nxt;
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_abort   <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_mem_addr <= {r_adr, w_beat_nxt};
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_instr   <= NOP;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_abort   <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!instrreq) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instrF     = r_instr;
  assign instrabort = r_abort;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign fetch_err  = r_err;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: transaction-level reference model, per-cycle compare, directed and random fetches.
module tb_instr_fetch_ctrl;

  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk;
  logic          reset;
  logic          instrreq;
  logic [31:0]   instradr;
  logic [31:0]   instrF;
  logic          instrabort;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_ack;
  logic          flush;
  logic          fetch_err;

  instr_fetch_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT), .NOP(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .instrreq  (instrreq),
    .instradr  (instradr),
    .instrF    (instrF),
    .instrabort(instrabort),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .flush     (flush),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: byte memory, buffer contents, and what the outputs must show right now.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          m_valid;
  logic [AW-3:0] m_tag;
  logic [31:0]   m_data;
  logic          exp_abort, exp_req, exp_err;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_instr;
  logic          chk_en = 1'b0;
  int            w_plan [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("instrabort", {31'd0, instrabort}, {31'd0, exp_abort});
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      check("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
      if (exp_req) check("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
      if (!exp_abort) check("instrF", instrF, exp_instr);
    end
  end

  task automatic step(input bit fm);
    flush = fm;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (fm) m_valid = 1'b0;
  endtask

  // One fetch transaction. drop_beat >= 0 releases instrreq when that beat is due.
  task automatic do_fetch(input logic [31:0] adr, input bit fl, input int drop_beat,
                          input bit flush_mid, input int hold,
                          output int lat, output logic [31:0] got);
    logic [AW-3:0] tag;
    logic [AW-1:0] base;
    logic [31:0]   word;
    bit            hit, ended, done_ok, fm, f;
    tag = adr[AW-1:2];
    base = {tag, 2'b00};
    word = '0; lat = 0; got = '0; ended = 0; done_ok = 0;
    instrreq = 1'b1; instradr = adr; mem_ack = 1'b0;
    hit = m_valid && (m_tag == tag) && !fl;
    step(fl); lat++;
    if (hit) begin
      exp_abort = 1'b0; exp_instr = m_data; done_ok = 1;
    end else begin
      exp_req = 1'b1; exp_addr = base;
      for (int b = 0; b < 4 && !ended; b++) begin
        for (int w = 0; !ended; w++) begin
          fm = flush_mid && (b == 1) && (w == 0);
          instradr = $urandom;
          if (b == drop_beat) begin
            instrreq = 1'b0;
            step(fm);
            exp_req = 1'b0;
            mem_ack = 1'b1; mem_rdata = $urandom;
            step(0);
            mem_ack = 1'b0;
            ended = 1;
          end else if (w == w_plan[b]) begin
            mem_ack = 1'b1; mem_rdata = mem[int'(base) + b];
            word[31 - 8*b -: 8] = mem[int'(base) + b];
            step(fm); lat++;
            mem_ack = 1'b0;
            if (b == 3) begin
              exp_req = 1'b0; exp_abort = 1'b0; exp_instr = word;
              m_valid = 1'b1; m_tag = tag; m_data = word;
              done_ok = 1; ended = 1;
            end else begin
              exp_addr = base + AW'(b + 1);
            end
            break;
          end else begin
            mem_ack = 1'b0; mem_rdata = $urandom;
            step(fm); lat++;
            if (w + 1 == TIMEOUT) begin
              exp_req = 1'b0; exp_abort = 1'b0; exp_instr = 32'h0; exp_err = 1'b1;
              done_ok = 1; ended = 1;
            end
          end
        end
      end
    end
    if (done_ok) begin
      for (int i = 0; i < hold; i++) begin
        instradr = $urandom; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        f = ($urandom_range(0, 3) == 0);
        step(f);
      end
      got = instrF;
      mem_ack = 1'b0; instrreq = 1'b0;
      step(0);
      exp_abort = 1'b1;
    end
  endtask

  int            lat;
  logic [31:0]   got;
  logic [AW-3:0] pool [4];
  logic [31:0]   adr;
  int            r;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
    mem[16'h40] = 8'h8C; mem[16'h41] = 8'h01; mem[16'h42] = 8'h00; mem[16'h43] = 8'h04;
    mem[16'h44] = 8'h12; mem[16'h45] = 8'h34; mem[16'h46] = 8'h56; mem[16'h47] = 8'h78;
    for (int b = 0; b < 4; b++) w_plan[b] = 0;
    reset = 1'b1; instrreq = 1'b0; instradr = '0; mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    exp_abort = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_instr = '0;
    step(0);
    chk_en = 1'b1;
    step(0);
    check("rst_instrF", instrF, 32'h0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    reset = 1'b0;
    step(0);

    // Miss with zero-wait memory, then a buffered repeat.
    do_fetch(32'h40, 0, -1, 0, 2, lat, got);
    check("t1_lat", lat, 5);
    check("t1_word", got, 32'h8C01_0004);
    do_fetch(32'h40, 0, -1, 0, 1, lat, got);
    check("t2_hit_lat", lat, 1);
    check("t2_word", got, 32'h8C01_0004);

    // Flush while idle, then flush coincident with the request: both miss.
    instrreq = 1'b0;
    step(1);
    do_fetch(32'h40, 0, -1, 0, 0, lat, got);
    check("t3_flush_lat", lat, 5);
    do_fetch(32'h40, 1, -1, 0, 0, lat, got);
    check("t3_flushreq_lat", lat, 5);
    check("t3_word", got, 32'h8C01_0004);

    // Beat 2 never acknowledged: NOP word, sticky error, buffer left alone.
    w_plan[2] = TIMEOUT;
    do_fetch(32'h80, 0, -1, 0, 1, lat, got);
    check("t4_lat", lat, 1 + 2 + TIMEOUT);
    check("t4_word", got, 32'h0);
    check("t4_err", {31'd0, fetch_err}, 32'h1);
    w_plan[2] = 0;
    do_fetch(32'h40, 0, -1, 0, 0, lat, got);
    check("t4_buf_kept_lat", lat, 1);
    do_fetch(32'h80, 0, -1, 0, 0, lat, got);
    check("t4_refetch_lat", lat, 5);

    // Request released after two beats, then a clean fetch of the next word.
    do_fetch(32'h200, 0, 2, 0, 0, lat, got);
    do_fetch(32'h44, 0, -1, 0, 1, lat, got);
    check("t5_lat", lat, 5);
    check("t5_word", got, 32'h1234_5678);

    pool[0] = 14'h10; pool[1] = 14'h11; pool[2] = 14'h400; pool[3] = 14'h3FFF;
    for (int n = 0; n < 150; n++) begin
      adr = $urandom;
      adr[AW-1:2] = pool[$urandom_range(0, 3)];
      for (int b = 0; b < 4; b++) begin
        r = $urandom_range(0, 39);
        w_plan[b] = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 :
                    (r < 30) ? 0 : $urandom_range(1, 4);
      end
      do_fetch(adr, $urandom_range(0, 9) == 0,
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1,
               $urandom_range(0, 9) == 0, $urandom_range(0, 3), lat, got);
      if ($urandom_range(0, 3) == 0) step($urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a fetch with mem_req high.
    for (int b = 0; b < 4; b++) w_plan[b] = 0;
    do_fetch(32'h44, 0, -1, 0, 0, lat, got);
    instrreq = 1'b1; instradr = 32'h300;
    step(0);
    exp_req = 1'b1; exp_addr = 16'h300;
    mem_ack = 1'b1; mem_rdata = mem[16'h300];
    step(0);
    exp_addr = 16'h301;
    mem_ack = 1'b0; reset = 1'b1;
    step(0);
    exp_req = 1'b0; exp_abort = 1'b1; exp_err = 1'b0; m_valid = 1'b0;
    check("t6_instrF", instrF, 32'h0);
    check("t6_mem_addr", {16'd0, mem_addr}, 32'h0);
    check("t6_mem_req", {31'd0, mem_req}, 32'h0);
    check("t6_err", {31'd0, fetch_err}, 32'h0);
    reset = 1'b0; instrreq = 1'b0;
    step(0);
    do_fetch(32'h44, 0, -1, 0, 1, lat, got);
    check("t6_after_rst_lat", lat, 5);
    check("t6_after_rst_word", got, 32'h1234_5678);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
